// File: rtl/uart_threshold_bank.sv
// uart_threshold_bank: UART-driven bank of saturating threshold registers.
// Single-byte ASCII commands select a channel ('A'+k), step its value up ('w') or
// down ('s'), read it back ('r') or restore its default ('d'). Each accepted command
// is echoed, and for value commands the channel value is then sent LSB-first.
module uart_threshold_bank #(
    parameter int unsigned NUM_CH = 7,
    parameter int unsigned WIDTH  = 16,
    parameter bit          SIGNED = 1'b1,
    // Packed per-channel limits, channel k at [k*WIDTH +: WIDTH] (ch6 is leftmost).
    parameter logic [NUM_CH*WIDTH-1:0] CH_MIN = {
        16'hFFF4, 16'd32, 16'hFFF4, 16'd32, 16'hFFF4, 16'd32, 16'd50
    },
    parameter logic [NUM_CH*WIDTH-1:0] CH_MAX = {
        16'd27, 16'd50, 16'd27, 16'd50, 16'd27, 16'd50, 16'd5000
    },
    parameter logic [NUM_CH*WIDTH-1:0] CH_STEP = {
        16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd50
    },
    parameter logic [NUM_CH*WIDTH-1:0] CH_DEFAULT = {
        16'd16, 16'd35, 16'd16, 16'd35, 16'd16, 16'd35, 16'd2550
    }
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [7:0]              i_rx_data,
    input  logic                    i_rx_valid,
    input  logic                    i_tx_idle,
    output logic [7:0]              o_tx_data,
    output logic                    o_tx_start,
    output logic [NUM_CH*WIDTH-1:0] o_th_flat,
    output logic [4:0]              o_sel,
    output logic                    o_busy,
    output logic                    o_rx_drop
);

    localparam int unsigned NBYTES    = (WIDTH + 7) / 8;
    localparam int unsigned EXT_W     = NBYTES * 8;
    localparam logic [2:0]  LAST_BYTE = 3'(NBYTES - 1);

    localparam logic [7:0] CMD_INC  = 8'h77; // 'w'
    localparam logic [7:0] CMD_DEC  = 8'h73; // 's'
    localparam logic [7:0] CMD_READ = 8'h72; // 'r'
    localparam logic [7:0] CMD_DEF  = 8'h64; // 'd'
    localparam logic [7:0] CHAR_A   = 8'h41; // 'A'

    typedef enum logic [2:0] {StIdle, StEcho, StGap, StUpdate, StSend} state_e;

    state_e                  r_state;
    logic [NUM_CH*WIDTH-1:0] r_th;
    logic [4:0]              r_sel;
    logic [7:0]              r_cmd;
    logic                    r_is_sel;   // current sequence is a channel select
    logic                    r_in_send;  // GAP belongs to the value-send phase
    logic [2:0]              r_byte_idx;
    logic                    r_tx_start;
    logic [7:0]              r_tx_data;

    logic [7:0]       w_off;
    logic             w_is_chan;
    logic             w_is_op;
    logic             w_busy;
    logic [31:0]      w_base;
    logic [WIDTH-1:0] w_cur;
    logic [WIDTH-1:0] w_min;
    logic [WIDTH-1:0] w_max;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_def;
    logic [WIDTH:0]   w_cur_x;
    logic [WIDTH:0]   w_min_x;
    logic [WIDTH:0]   w_max_x;
    logic [WIDTH:0]   w_step_x;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_hi_lim;
    logic [WIDTH:0]   w_lo_lim;
    logic [WIDTH-1:0] w_new;
    logic [EXT_W-1:0] w_ext;
    logic [7:0]       w_byte;

    // Command decode of the received byte
    assign w_off     = i_rx_data - CHAR_A;
    assign w_is_chan = (i_rx_data >= CHAR_A) && (32'(w_off) < NUM_CH);
    assign w_is_op   = (i_rx_data == CMD_INC) || (i_rx_data == CMD_DEC) ||
                       (i_rx_data == CMD_READ) || (i_rx_data == CMD_DEF);

    // Selected channel's current value and limits
    assign w_base = 32'(r_sel) * WIDTH;
    assign w_cur  = r_th[w_base +: WIDTH];
    assign w_min  = CH_MIN[w_base +: WIDTH];
    assign w_max  = CH_MAX[w_base +: WIDTH];
    assign w_step = CH_STEP[w_base +: WIDTH];
    assign w_def  = CH_DEFAULT[w_base +: WIDTH];

    // One extra bit (sign- or zero-extended) keeps the saturation math from wrapping
    assign w_cur_x  = {SIGNED & w_cur[WIDTH-1], w_cur};
    assign w_min_x  = {SIGNED & w_min[WIDTH-1], w_min};
    assign w_max_x  = {SIGNED & w_max[WIDTH-1], w_max};
    assign w_step_x = {SIGNED & w_step[WIDTH-1], w_step};
    assign w_sum    = w_cur_x + w_step_x;
    assign w_diff   = w_cur_x - w_step_x;
    assign w_hi_lim = w_max_x - w_step_x;
    assign w_lo_lim = w_min_x + w_step_x;

    // Next value of the selected channel for the latched command
    always_comb begin
        w_new = w_cur;
        case (r_cmd)
            CMD_INC: w_new = ($signed(w_cur_x) > $signed(w_hi_lim)) ? w_max : w_sum[WIDTH-1:0];
            CMD_DEC: w_new = ($signed(w_cur_x) < $signed(w_lo_lim)) ? w_min : w_diff[WIDTH-1:0];
            CMD_DEF: w_new = w_def;
            default: w_new = w_cur;
        endcase
    end

    // Byte to transmit: value padded to whole bytes, sign- or zero-filled
    always_comb begin
        w_ext            = (SIGNED && w_cur[WIDTH-1]) ? '1 : '0;
        w_ext[WIDTH-1:0] = w_cur;
        w_byte           = w_ext[{r_byte_idx, 3'b000} +: 8];
    end

    // Command sequencer, threshold storage and registered transmit outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_th       <= CH_DEFAULT;
            r_sel      <= '0;
            r_cmd      <= '0;
            r_is_sel   <= 1'b0;
            r_in_send  <= 1'b0;
            r_byte_idx <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_start <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_rx_valid && w_is_chan) begin
                        r_sel     <= w_off[4:0];
                        r_cmd     <= i_rx_data;
                        r_is_sel  <= 1'b1;
                        r_in_send <= 1'b0;
                        r_state   <= StEcho;
                    end else if (i_rx_valid && w_is_op) begin
                        r_cmd     <= i_rx_data;
                        r_is_sel  <= 1'b0;
                        r_in_send <= 1'b0;
                        r_state   <= StEcho;
                    end
                end
                StEcho: begin
                    if (i_tx_idle) begin
                        r_tx_start <= 1'b1;
                        r_tx_data  <= r_cmd;
                        r_state    <= StGap;
                    end
                end
                StGap: begin
                    // tx_idle is not looked at here: the transmitter lags by a cycle
                    if (!r_in_send) begin
                        r_state <= r_is_sel ? StIdle : StUpdate;
                    end else if (r_byte_idx == LAST_BYTE) begin
                        r_in_send <= 1'b0;
                        r_state   <= StIdle;
                    end else begin
                        r_byte_idx <= r_byte_idx + 3'd1;
                        r_state    <= StSend;
                    end
                end
                StUpdate: begin
                    r_th[w_base +: WIDTH] <= w_new;
                    r_byte_idx            <= '0;
                    r_in_send             <= 1'b1;
                    r_state               <= StSend;
                end
                StSend: begin
                    if (i_tx_idle) begin
                        r_tx_start <= 1'b1;
                        r_tx_data  <= w_byte;
                        r_state    <= StGap;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign w_busy     = (r_state != StIdle);
    assign o_busy     = w_busy;
    assign o_rx_drop  = i_rx_valid & w_busy;
    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;
    assign o_th_flat  = r_th;
    assign o_sel      = r_sel;

endmodule
